tick_period_monitor: RTL

//  Consumer side of the counter tick: watches a single-cycle strobe (e.g. a counter tc or a

---
 rtl/sdr_timing_pkg.sv | 13 +
 rtl/tick_interval_counter.sv | 30 +++
 rtl/tick_period_monitor.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sdr_timing_pkg.sv
// Shared timing-monitor definitions: monitor state encoding
// and error-counter width, reused by the SDR timing monitors.
package sdr_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } mon_state_e;

  localparam int ERR_W = 16;

endpackage

// File: rtl/tick_interval_counter.sv
// Saturating interval counter for the tick period monitor.
// Ports: clk, rst (sync, active-high), enable (hold when 0),
// restart (load 1), cnt (current interval), at_limit (cnt==MAX).
module tick_interval_counter #(
  parameter int MAX = 12,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         restart,
  output logic [W-1:0] cnt,
  output logic         at_limit
);

  assign at_limit = (cnt == W'(MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (enable) begin
      if (restart) begin
        cnt <= W'(1);
      end else if (!at_limit) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_period_monitor.sv
// Tick period monitor: measures strobe interval, checks it
// against NOMINAL +/- TOL, reports lock / early / missing.
// Ports: clk, rst (sync, active-high), enable, tick_in;
// period, period_valid, locked, early, missing;
// err_count (only when TICK_MON_ERRCNT_EN is defined).
module tick_period_monitor
  import sdr_timing_pkg::*;
#(
  parameter int  NOMINAL    = 50000000,
  parameter int  TOL        = 2,
  parameter int  LOCK_COUNT = 4,
  localparam int WIDTH      = $clog2(NOMINAL + TOL + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             tick_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             early,
  output logic             missing
`ifdef TICK_MON_ERRCNT_EN
  ,
  output logic [ERR_W-1:0] err_count
`endif
);

  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0] LO = WIDTH'(NOMINAL - TOL);
  localparam logic [RW-1:0] RUN_LAST = RW'(LOCK_COUNT - 1);

  mon_state_e       state;
  logic [RW-1:0]    run;
  logic [WIDTH-1:0] cnt;
  logic             at_limit;
  logic             active;
  logic             early_hit;
  logic             miss_hit;

  tick_interval_counter #(
    .MAX (NOMINAL + TOL),
    .W   (WIDTH)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .restart  (tick_in),
    .cnt      (cnt),
    .at_limit (at_limit)
  );

  // A tick at the limit is a good tick, so missing needs !tick_in.
  always_comb begin
    active    = enable && (state != ST_IDLE);
    early_hit = active && tick_in && (cnt < LO);
    miss_hit  = active && !tick_in && at_limit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      run          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      early        <= 1'b0;
      missing      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      early        <= 1'b0;
      missing      <= 1'b0;
      if (enable) begin
        unique case (state)
          ST_IDLE: begin
            if (tick_in) begin
              state <= ST_ACQUIRE;
              run   <= '0;
            end
          end
          ST_ACQUIRE, ST_LOCKED: begin
            if (tick_in) begin
              period       <= cnt;
              period_valid <= 1'b1;
              if (early_hit) begin
                early  <= 1'b1;
                locked <= 1'b0;
                run    <= '0;
                state  <= ST_ACQUIRE;
              end else if (state == ST_ACQUIRE) begin
                run <= run + 1'b1;
                if (run == RUN_LAST) begin
                  state  <= ST_LOCKED;
                  locked <= 1'b1;
                end
              end
            end else if (miss_hit) begin
              missing <= 1'b1;
              locked  <= 1'b0;
              run     <= '0;
              state   <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef TICK_MON_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if ((early_hit || miss_hit) && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule
